// File: rtl/field_cfg_loader.sv
// Streams a predefined Game of Life starting pattern into field memory, one row per handshake.
// Optional build macro FCL_RANDOM_EN: a NO_REQ load fills the field from a 32-bit Galois LFSR.
package field_cfg_pkg;
  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;
endpackage

module field_cfg_loader
  import field_cfg_pkg::*;
#(
  parameter int          FIELD_W   = 32,
  parameter int          FIELD_H   = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_go,
  input  load_cfg_req_t              i_cfg_req,
  output logic                       o_is_loading,
  output logic                       o_done,
  output logic                       o_wr_en,
  input  logic                       i_wr_ready,
  output logic [$clog2(FIELD_H)-1:0] o_wr_addr,
  output logic [FIELD_W-1:0]         o_wr_data
);

  localparam int AW = $clog2(FIELD_H);
  localparam logic [AW-1:0] LAST_ROW = AW'(FIELD_H - 1);
  localparam logic [AW-1:0] MID_ROW  = AW'(FIELD_H / 2);

  if (FIELD_H < 4) begin : g_bad_height
    $error("field_cfg_loader: FIELD_H must be at least 4");
  end
  if (LFSR_SEED == 32'h0) begin : g_bad_seed
    $error("field_cfg_loader: LFSR_SEED must be non-zero");
  end

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  load_cfg_req_t cfg_q, cfg_d;
  logic          done_q, done_d;
  logic          xfer;
  logic [FIELD_W-1:0] pattern;

  assign xfer = (state_q == LOAD) && i_wr_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_go) begin
          state_d = LOAD;
          row_d   = '0;
          cfg_d   = i_cfg_req;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cfg_q   <= NO_REQ;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

`ifdef FCL_RANDOM_EN
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [31:0] lfsr_q, lfsr_d;

  // Reseeding on every accepted go makes repeated random loads reproducible.
  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_q == IDLE) && i_go) begin
      lfsr_d = LFSR_SEED;
    end else if (xfer) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  always_comb begin
    pattern = '0;
    case (cfg_q)
      CFG_1: begin
        if (row_q == AW'(1)) pattern[2] = 1'b1;
        if (row_q == AW'(2)) pattern[3] = 1'b1;
        if (row_q == AW'(3)) pattern[3:1] = 3'b111;
      end
      CFG_2: begin
        if ((row_q == MID_ROW - AW'(1)) || (row_q == MID_ROW) || (row_q == MID_ROW + AW'(1)))
          pattern[FIELD_W/2] = 1'b1;
      end
      default: begin
`ifdef FCL_RANDOM_EN
        pattern = lfsr_q[FIELD_W-1:0];
`else
        pattern = '0;
`endif
      end
    endcase
  end

  assign o_is_loading = (state_q == LOAD);
  assign o_wr_en      = o_is_loading;
  assign o_done       = done_q;
  assign o_wr_addr    = row_q;
  assign o_wr_data    = o_is_loading ? pattern : '0;

endmodule

// File: tb/tb_field_cfg_loader.sv
// Self-checking bench for field_cfg_loader: a scoreboard queue holds expected row writes,
// while scenario tasks check busy timing, done pulses, backpressure and reset behaviour.
module tb_field_cfg_loader;
  import field_cfg_pkg::*;

  localparam int W = 32;
  localparam int H = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_go = 1'b0;
  load_cfg_req_t i_cfg_req = NO_REQ;
  logic          i_wr_ready = 1'b1;
  logic          o_is_loading, o_done, o_wr_en;
  logic [4:0]    o_wr_addr;
  logic [W-1:0]  o_wr_data;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } row_t;

  row_t exp_q[$];
  row_t mon_exp;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  field_cfg_loader #(.FIELD_W(W), .FIELD_H(H), .LFSR_SEED(32'hACE1_2468)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_go(i_go),
    .i_cfg_req(i_cfg_req),
    .o_is_loading(o_is_loading),
    .o_done(o_done),
    .o_wr_en(o_wr_en),
    .i_wr_ready(i_wr_ready),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic logic [31:0] model_row(input load_cfg_req_t cfg, input int r, input logic [31:0] rnd);
    case (cfg)
      CFG_1: begin
        if (r == 1) return 32'h0000_0004;
        if (r == 2) return 32'h0000_0008;
        if (r == 3) return 32'h0000_000E;
        return 32'h0;
      end
      CFG_2: return (r == 15 || r == 16 || r == 17) ? 32'h0001_0000 : 32'h0;
      default: begin
`ifdef FCL_RANDOM_EN
        return rnd;
`else
        return (rnd == 32'h0) ? 32'h0 : 32'h0;
`endif
      end
    endcase
  endfunction

  // Every accepted row write is popped from the scoreboard and compared in order.
  always @(negedge clk) begin
    if (rst_n && o_wr_en && i_wr_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", o_wr_addr, o_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_wr_addr, o_wr_data} !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL row_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   o_wr_addr, o_wr_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input load_cfg_req_t cfg);
    logic [31:0] rnd = 32'hACE1_2468;
    row_t e;
    for (int r = 0; r < H; r++) begin
      e.addr = 5'(r);
      e.data = model_row(cfg, r, rnd);
      exp_q.push_back(e);
      rnd = lfsr_next(rnd);
    end
    i_cfg_req = cfg;
    i_go = 1'b1;
    step();
    i_go = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready alternating, low first; mode 2: ready high with stray go/cfg changes.
  task automatic run_cycles(input int n, input int mode, output int load_cnt, output int first_load,
                            output int done_cnt, output int done_cyc, output int unstable);
    logic        held = 1'b0;
    logic [4:0]  ha = '0;
    logic [31:0] hd = '0;
    load_cnt = 0; first_load = -1; done_cnt = 0; done_cyc = -1; unstable = 0;
    for (int c = 1; c <= n; c++) begin
      i_wr_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
      if (mode == 2) begin
        i_go = (c == 5 || c == 10);
        i_cfg_req = (c >= 5) ? CFG_2 : CFG_1;
      end
      @(negedge clk);
      if (o_is_loading) begin
        load_cnt++;
        if (first_load < 0) first_load = c;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (held && o_is_loading && ({o_wr_addr, o_wr_data} !== {ha, hd})) unstable++;
      held = o_wr_en && !i_wr_ready;
      ha = o_wr_addr;
      hd = o_wr_data;
      step();
    end
    i_wr_ready = 1'b1;
    i_go = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    n_checks += 5;
    if (o_is_loading !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_loading: got %b, expected 0", o_is_loading); end
    if (o_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b, expected 0", o_done); end
    if (o_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_en: got %b, expected 0", o_wr_en); end
    if (o_wr_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0d, expected 0", o_wr_addr); end
    if (o_wr_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h, expected 0", o_wr_data); end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (o_is_loading !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_after_reset: got %b, expected 0", o_is_loading); end
  endtask

  task automatic test_load(input load_cfg_req_t cfg, input string name);
    int lc, fl, dc, dcy, us;
    step();
    start_load(cfg);
    run_cycles(40, 0, lc, fl, dc, dcy, us);
    n_checks += 5;
    if (fl !== 1) begin n_fail++; $display("[TB] FAIL %s_first_busy: got cycle %0d, expected 1", name, fl); end
    if (lc !== 32) begin n_fail++; $display("[TB] FAIL %s_busy_cycles: got %0d, expected 32", name, lc); end
    if (dc !== 1) begin n_fail++; $display("[TB] FAIL %s_done_count: got %0d, expected 1", name, dc); end
    if (dcy !== 33) begin n_fail++; $display("[TB] FAIL %s_done_cycle: got %0d, expected 33", name, dcy); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL %s_rows_left: got %0d, expected 0", name, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int lc, fl, dc, dcy, us;
    step();
    start_load(CFG_1);
    run_cycles(80, 1, lc, fl, dc, dcy, us);
    n_checks += 5;
    if (lc !== 64) begin n_fail++; $display("[TB] FAIL bp_busy_cycles: got %0d, expected 64", lc); end
    if (dcy !== 65) begin n_fail++; $display("[TB] FAIL bp_done_cycle: got %0d, expected 65", dcy); end
    if (dc !== 1) begin n_fail++; $display("[TB] FAIL bp_done_count: got %0d, expected 1", dc); end
    if (us !== 0) begin n_fail++; $display("[TB] FAIL bp_hold_stable: got %0d changes, expected 0", us); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL bp_rows_left: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_ignore_go();
    int lc, fl, dc, dcy, us;
    step();
    start_load(CFG_1);
    run_cycles(45, 2, lc, fl, dc, dcy, us);
    n_checks += 3;
    if (lc !== 32) begin n_fail++; $display("[TB] FAIL ign_busy_cycles: got %0d, expected 32", lc); end
    if (dc !== 1) begin n_fail++; $display("[TB] FAIL ign_done_count: got %0d, expected 1", dc); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL ign_rows_left: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    bit found = 0;
    step();
    start_load(CFG_1);
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (o_is_loading && o_wr_addr == 5'd10) found = 1;
      else step();
    end
    n_checks++;
    if (!found) begin n_fail++; $display("[TB] FAIL mid_row10_seen: got not seen, expected seen"); end
    #1 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (o_is_loading !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_loading: got %b, expected 0", o_is_loading); end
    if (o_done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_done: got %b, expected 0", o_done); end
    if (o_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_wr_en: got %b, expected 0", o_wr_en); end
    if (o_wr_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_addr: got %0d, expected 0", o_wr_addr); end
    if (o_wr_data !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_data: got %h, expected 0", o_wr_data); end
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    test_load(CFG_2, "restart");
  endtask

  task automatic test_no_req();
    test_load(NO_REQ, "noreq_a");
    test_load(NO_REQ, "noreq_b");
  endtask

  initial begin
    $display("[TB] field_cfg_loader bench start");
    test_reset();
    test_load(CFG_1, "cfg1");
    test_load(CFG_2, "cfg2");
    test_backpressure();
    test_ignore_go();
    test_reset_mid_load();
    test_no_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
